spi_master_link: RTL and testbench
==================================

Name: spi_master_link

Overview:
- SPI master (mode 0, MSB first) that drives SPI_CLK, SPI_MOSI and SPI_CS, and samples SPI_MISO.
- It is the initiator end of the 4-wire SPI link whose slave endpoint sits inside mtl_controller.
- Uses: an FPGA-to-FPGA link, and a synthesizable stimulus source for on-board loopback checks of the slave.
- User side is a valid/ready word interface with a keep-select option for multi-word frames.

Parameters:
WORD_W, 8, bits per SPI word, must be >= 2
CLK_DIV, 4, iCLK cycles per SPI_CLK half-period, must be >= 1
CS_IDLE, 4, minimum iCLK cycles SPI_CS stays high between frames, must be >= 1

Ports:
iCLK  in  1  system clock
iRST  in  1  synchronous, active-high reset
iValid  in  1  TX word offered
oReady  out  1  block can accept a word this cycle
iData  in  WORD_W  word to transmit
iKeepCs  in  1  sampled with the accepted word; 1 = keep SPI_CS low after this word
oRxValid  out  1  one-cycle pulse, oRxData valid
oRxData  out  WORD_W  word received on SPI_MISO
oBusy  out  1  high whenever SPI_CS is low or in the inter-frame gap
SPI_CLK  out  1  serial clock, idles low
SPI_MOSI  out  1  serial data out
SPI_MISO  in  1  serial data in
SPI_CS  out  1  chip select, active low

Behaviour:
- Reset values: oReady=1, oRxValid=0, oRxData=0, oBusy=0, SPI_CLK=0, SPI_MOSI=0, SPI_CS=1; FSM=IDLE.
- Reset mid-word: the next cycle forces the same values. No oRxValid pulse, partial word discarded.
- Handshake: a word is accepted on a cycle where iValid && oReady.
  - iData and iKeepCs are latched on accept.
  - iValid while oReady=0 is ignored; iData need not be held.
- FSM states: IDLE, SHIFT, HOLD, GAP.
- IDLE: oReady=1, SPI_CS=1. On accept -> SHIFT.
- SHIFT, cycle-level (accept at cycle 0):
  - Cycle 1: SPI_CS=0, SPI_MOSI=data[WORD_W-1], SPI_CLK=0.
  - A half-period counter toggles SPI_CLK every CLK_DIV cycles.
  - Rising edge k (k=1..WORD_W) at cycle 1+(2k-1)*CLK_DIV: SPI_MISO is sampled into the shift register LSB (registered on iCLK at that cycle).
  - Each falling edge except the last: SPI_MOSI advances to the next lower bit.
  - Last falling edge at cycle T=1+2*WORD_W*CLK_DIV: oRxValid=1 for exactly that cycle, oRxData updated (MSB = first sampled bit).
  - oRxData holds its value until the next word completes.
  - Exit: latched iKeepCs=1 -> HOLD, else -> GAP.
- HOLD: SPI_CS stays 0, SPI_CLK=0, oReady=1, SPI_MOSI holds its last bit.
  - On accept, SPI_MOSI=new MSB next cycle and SHIFT restarts with the same timing. SPI_CS is never deasserted between the two words.
  - Frame termination: there is no separate release input. The user ends a frame by sending its final word with iKeepCs=0.
- GAP: SPI_CS=1, SPI_MOSI=0, oReady=0 for CS_IDLE cycles, then -> IDLE with oReady=1.
  - For a single-word frame, the earliest next accept is cycle T+CS_IDLE+1.
- oBusy = (state != IDLE).
- Counter width: clog2(CLK_DIV) for the half-period counter, clog2(WORD_W+1) for the bit counter. No wrap-around inside a word.

Test Plan:
- WORD_W=8, CLK_DIV=2, SPI_MISO looped to SPI_MOSI, send 0xA5 with iKeepCs=0 -> exactly 8 SPI_CLK rising edges, oRxValid at cycle 33 after accept, oRxData=0xA5, SPI_CS high from cycle 34 for 4 cycles, oReady back at cycle 38.
- SPI_MISO tied to 1, send 0x00 -> SPI_MOSI stays 0 for the whole word, oRxData=0xFF.
- Send 0x3C (iKeepCs=1) then 0xC3 (iKeepCs=0), back-to-back with loopback -> SPI_CS low continuously across both words, 16 rising edges, oRxData 0x3C then 0xC3, one GAP only at the end.
- Hold iValid=1 with a changing iData during SHIFT -> only the first word is transmitted. The second word is accepted only after GAP ends.
- Assert iRST at cycle 10 of a word -> next cycle SPI_CS=1, SPI_CLK=0, oReady=1, no oRxValid pulse. A fresh 0x81 then transfers correctly.
- CLK_DIV=1 -> SPI_CLK toggles every cycle, oRxValid at cycle 17 after accept for WORD_W=8.

Source files
------------

// File: rtl/spi_master_link.sv
// spi_master_link: SPI mode-0 master, MSB first, valid/ready word side with keep-CS multi-word frames.
module spi_master_link #(
    parameter int WORD_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int CS_IDLE = 4
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iValid,
    output logic              oReady,
    input  logic [WORD_W-1:0] iData,
    input  logic              iKeepCs,
    output logic              oRxValid,
    output logic [WORD_W-1:0] oRxData,
    output logic              oBusy,
    output logic              SPI_CLK,
    output logic              SPI_MOSI,
    input  logic              SPI_MISO,
    output logic              SPI_CS
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(WORD_W + 1);
    localparam int GW = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     div_q, div_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              sclk_q, sclk_d;
    logic              keep_q, keep_d;
    logic [WORD_W-1:0] tx_q, tx_d;
    logic [WORD_W-1:0] rx_q, rx_d;
    logic [WORD_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              accept, toggle, cs_act;

    assign oReady   = (state_q == IDLE) || (state_q == HOLD);
    assign accept   = iValid && oReady;
    assign toggle   = div_q == DW'(CLK_DIV - 1);
    assign cs_act   = (state_q == SHIFT) || (state_q == HOLD);
    assign SPI_CS   = !cs_act;
    assign SPI_MOSI = cs_act && tx_q[WORD_W-1];
    assign SPI_CLK  = sclk_q;
    assign oBusy    = state_q != IDLE;
    assign oRxValid = rx_valid_q;
    assign oRxData  = rx_data_q;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        gap_d      = gap_q;
        sclk_d     = sclk_q;
        keep_d     = keep_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        if (accept) begin
            state_d = SHIFT;
            tx_d    = iData;
            keep_d  = iKeepCs;
            div_d   = '0;
            bit_d   = '0;
            sclk_d  = 1'b0;
        end else if (state_q == SHIFT) begin
            // bit_q counts falling edges; the cycle after the last one is the completion cycle
            if (bit_q == BW'(WORD_W)) begin
                state_d = keep_q ? HOLD : GAP;
                gap_d   = '0;
            end else begin
                div_d = toggle ? '0 : div_q + 1'b1;
                if (toggle) begin
                    sclk_d = !sclk_q;
                    if (!sclk_q) begin
                        rx_d = {rx_q[WORD_W-2:0], SPI_MISO};
                    end else begin
                        bit_d = bit_q + 1'b1;
                        if (bit_q == BW'(WORD_W - 1)) begin
                            rx_data_d  = rx_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            tx_d = {tx_q[WORD_W-2:0], 1'b0};
                        end
                    end
                end
            end
        end else if (state_q == GAP) begin
            gap_d = gap_q + 1'b1;
            if (gap_q == GW'(CS_IDLE - 1)) state_d = IDLE;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            gap_q      <= '0;
            sclk_q     <= 1'b0;
            keep_q     <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
            sclk_q     <= sclk_d;
            keep_q     <= keep_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end
endmodule

// File: tb/tb_spi_master_link.sv
// tb_spi_master_link: directed vector bench for the SPI master, CLK_DIV=2 and CLK_DIV=1 instances.
module tb_spi_master_link;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       v0 = 1'b0, k0 = 1'b0, miso_one = 1'b0;
    logic [7:0] d0 = '0;
    logic       rdy0, rv0, busy0, sclk0, mosi0, miso0, cs0;
    logic [7:0] rd0;
    assign miso0 = miso_one ? 1'b1 : mosi0;

    logic       v1 = 1'b0;
    logic [7:0] d1 = '0;
    logic       rdy1, rv1, busy1, sclk1, mosi1, cs1;
    logic [7:0] rd1;

    spi_master_link #(.WORD_W(8), .CLK_DIV(2), .CS_IDLE(4)) u0 (
        .iCLK(clk), .iRST(rst), .iValid(v0), .oReady(rdy0), .iData(d0), .iKeepCs(k0),
        .oRxValid(rv0), .oRxData(rd0), .oBusy(busy0), .SPI_CLK(sclk0), .SPI_MOSI(mosi0),
        .SPI_MISO(miso0), .SPI_CS(cs0));

    spi_master_link #(.WORD_W(8), .CLK_DIV(1), .CS_IDLE(4)) u1 (
        .iCLK(clk), .iRST(rst), .iValid(v1), .oReady(rdy1), .iData(d1), .iKeepCs(1'b0),
        .oRxValid(rv1), .oRxData(rd1), .oBusy(busy1), .SPI_CLK(sclk1), .SPI_MOSI(mosi1),
        .SPI_MISO(mosi1), .SPI_CS(cs1));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Waits for oReady on a falling edge and offers the word there (that cycle is cycle 0).
    task automatic start(input logic [7:0] d, input logic k);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy0 && n < 100);
        chk("ready_wait", 32'(rdy0), 32'd1);
        v0 = 1'b1;
        d0 = d;
        k0 = k;
    endtask

    task automatic xfer(input bit hold, output logic [7:0] rx, output int t, output int rises,
                        output logic [7:0] mosi_w, output bit cs_ok);
        logic prev;
        prev = sclk0;
        rx = '0; t = 0; rises = 0; mosi_w = '0; cs_ok = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (hold) d0 = 8'($urandom);
            else v0 = 1'b0;
            if (cs0) cs_ok = 1'b0;
            if (sclk0 && !prev) begin
                rises++;
                mosi_w = {mosi_w[6:0], mosi0};
            end
            prev = sclk0;
            if (rv0) begin
                t = n;
                rx = rd0;
                break;
            end
        end
        if (t == 0) chk("rx_timeout", 32'd0, 32'd1);
    endtask

    task automatic gap_check(input string nm);
        bit ok = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (!cs0 || rdy0 || mosi0 || rv0 || !busy0) ok = 1'b0;
        end
        chk({nm, "_gap"}, 32'(ok), 32'd1);
        @(negedge clk);
        chk({nm, "_ready"}, 32'({rdy0, busy0}), 32'b10);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       one;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [5];

    initial begin
        logic [7:0] rx, mw;
        int t, r, r2, n;
        bit ok, ok2, seen;
        tbl = '{'{8'hA5, 1'b0, 8'hA5}, '{8'h00, 1'b1, 8'hFF}, '{8'h5A, 1'b0, 8'h5A},
                '{8'h96, 1'b1, 8'hFF}, '{8'h01, 1'b0, 8'h01}};

        repeat (3) @(negedge clk);
        chk("reset_outs", 32'({rdy0, rv0, busy0, sclk0, mosi0, cs0}), 32'b100001);
        chk("reset_rxdata", 32'(rd0), 32'h0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            miso_one = tbl[i].one;
            start(tbl[i].d, 1'b0);
            xfer(1'b0, rx, t, r, mw, ok);
            chk($sformatf("v%0d_rx", i), 32'(rx), 32'(tbl[i].exp));
            chk($sformatf("v%0d_cycle", i), 32'(t), 32'd33);
            chk($sformatf("v%0d_rises", i), 32'(r), 32'd8);
            chk($sformatf("v%0d_mosi", i), 32'(mw), 32'(tbl[i].d));
            chk($sformatf("v%0d_cs_low", i), 32'(ok), 32'd1);
            gap_check($sformatf("v%0d", i));
        end
        miso_one = 1'b0;

        start(8'h3C, 1'b1);
        xfer(1'b0, rx, t, r, mw, ok);
        chk("keep1_rx", 32'(rx), 32'h3C);
        chk("keep1_cycle", 32'(t), 32'd33);
        start(8'hC3, 1'b0);
        chk("hold_cs_clk", 32'({cs0, sclk0, busy0}), 32'b001);
        xfer(1'b0, rx, t, r2, mw, ok2);
        chk("keep2_rx", 32'(rx), 32'hC3);
        chk("keep2_cycle", 32'(t), 32'd33);
        chk("keep_rises", 32'(r + r2), 32'd16);
        chk("keep_cs_low", 32'(ok && ok2), 32'd1);
        gap_check("keep");

        start(8'h11, 1'b0);
        xfer(1'b1, rx, t, r, mw, ok);
        chk("held_mosi", 32'(mw), 32'h11);
        chk("held_rx", 32'(rx), 32'h11);
        d0 = 8'h77;
        gap_check("held");
        xfer(1'b0, rx, t, r, mw, ok);
        chk("held2_rx", 32'(rx), 32'h77);
        chk("held2_cycle", 32'(t), 32'd33);
        gap_check("held2");

        start(8'hF0, 1'b0);
        for (n = 1; n <= 10; n++) begin
            @(negedge clk);
            v0 = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_outs", 32'({cs0, sclk0, rdy0, rv0, busy0, mosi0}), 32'b101000);
        chk("midrst_rxdata", 32'(rd0), 32'h0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rv0) seen = 1'b1;
        end
        chk("midrst_no_pulse", 32'(seen), 32'd0);
        start(8'h81, 1'b0);
        xfer(1'b0, rx, t, r, mw, ok);
        chk("post_rst_rx", 32'(rx), 32'h81);
        chk("post_rst_cycle", 32'(t), 32'd33);
        gap_check("post_rst");

        @(negedge clk);
        chk("div1_ready", 32'(rdy1), 32'd1);
        v1 = 1'b1;
        d1 = 8'h6B;
        t = 0; r = 0; ok = sclk1;
        for (n = 1; n <= 100; n++) begin
            @(negedge clk);
            v1 = 1'b0;
            if (sclk1 && !ok) r++;
            ok = sclk1;
            if (rv1) begin
                t = n;
                rx = rd1;
                break;
            end
        end
        chk("div1_cycle", 32'(t), 32'd17);
        chk("div1_rx", 32'(rx), 32'h6B);
        chk("div1_rises", 32'(r), 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
